fifo_sync_flags: RTL
====================

Name: fifo_sync_flags

Overview:
Parametrised single-clock FIFO and the next generation of the team's basic FIFO. It adds:
- full DEPTH-entry usable capacity, reported through an occupancy count
- programmable almost-full and almost-empty thresholds
- overflow and underflow error pulses
- selectable standard or first-word-fall-through (FWFT) read mode

It sits between producer/consumer blocks such as UART, SPI and command parsers, where back-pressure and early-warning flags are needed.

Parameters:
DATA_LEN, 8, data word width in bits; must be >= 1.
DEPTH, 16, number of entries; power of two and >= 2.
AF_LEVEL, DEPTH-2, ALMOST_FULL_OW asserts when count >= AF_LEVEL; range 1..DEPTH.
AE_LEVEL, 2, ALMOST_EMPTY_OW asserts when count <= AE_LEVEL; range 0..DEPTH-1.
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
CLK_IW  in  1  single clock; all logic on the rising edge.
RST_N_IW  in  1  asynchronous, active-low reset.
DATA_IN_I  in  DATA_LEN  write data.
WRITE_EN_IW  in  1  write request.
READ_EN_IW  in  1  read request (in FWFT mode, acknowledges and pops the head word).
DATA_OUT_O  out  DATA_LEN  read data.
VALID_OR  out  1  DATA_OUT_O holds a word that was just read (FWFT=0 only; tied 0 when FWFT=1).
FULL_OW  out  1  count == DEPTH.
EMPTY_OW  out  1  count == 0.
ALMOST_FULL_OW  out  1  count >= AF_LEVEL.
ALMOST_EMPTY_OW  out  1  count <= AE_LEVEL.
COUNT_OR  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
OVERFLOW_OR  out  1  one-cycle pulse: a write was rejected.
UNDERFLOW_OR  out  1  one-cycle pulse: a read was rejected.

Behaviour:
- Pointers:
  - write_ptr and read_ptr are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - The low bits address memory and wrap naturally from DEPTH-1 to 0.
  - COUNT_OR is a registered up/down counter and must always equal write_ptr - read_ptr modulo 2*DEPTH.
- Acceptance, evaluated on pre-edge state:
  - wr_ok = WRITE_EN_IW && !FULL_OW
  - rd_ok = READ_EN_IW && !EMPTY_OW
- Simultaneous read and write:
  - Both accepted: both pointers advance and the count is unchanged.
  - At full: the read is accepted and the write is rejected (overflow pulse).
  - At empty: the write is accepted and the read is rejected (underflow pulse). There is no write-through bypass.
- Count update: count +1 on wr_ok only, -1 on rd_ok only, unchanged otherwise.
- Flags:
  - FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY are combinational decodes of COUNT_OR.
  - They therefore update in the same cycle the count changes.
- Error pulses:
  - OVERFLOW_OR = 1 for exactly the cycle after an edge where WRITE_EN_IW && FULL_OW.
  - UNDERFLOW_OR = 1 for exactly the cycle after an edge where READ_EN_IW && EMPTY_OW.
  - Rejected operations change no state: memory, pointers and count are untouched.
- Standard read mode (FWFT=0):
  - On rd_ok, DATA_OUT_O is registered with mem[read_ptr] and VALID_OR = 1 for one cycle.
  - Latency is one cycle from the read request to valid data.
  - DATA_OUT_O holds its last value otherwise.
- FWFT mode (FWFT=1):
  - DATA_OUT_O = mem[read_ptr] combinationally whenever EMPTY_OW = 0.
  - READ_EN_IW pops the head word.
  - A word written at edge N is visible on DATA_OUT_O after edge N.
  - DATA_OUT_O is don't-care while empty.
- Reset (RST_N_IW low, asynchronous assert):
  - Pointers, count, DATA_OUT_O register, VALID_OR, OVERFLOW_OR and UNDERFLOW_OR clear to 0.
  - Flags therefore read EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=(AF_LEVEL==0 ? 1 : 0), i.e. 0 for legal values.
  - Memory contents are not cleared; after reset they are unreachable.
- Reset mid-operation: any in-flight read or write in that cycle is discarded.
- Deassertion is used synchronously, via the team's reset synchroniser upstream.
- Elaboration check: $error if DATA_LEN < 1, DEPTH is not a power of two, DEPTH < 2, or AF_LEVEL/AE_LEVEL are out of range.

Test Plan:
(All scenarios use DATA_LEN=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1 unless stated.)
- Fill/drain, FWFT=0:
  - Write 0x11, 0x22, 0x33, 0x44 -> COUNT 1,2,3,4; ALMOST_FULL rises at count 3; FULL at 4.
  - Four reads -> VALID pulses carry 0x11..0x44 in order, each one cycle after its READ_EN; EMPTY=1 at the end.
- Overflow: at full, write 0x55 -> OVERFLOW_OR pulses for one cycle; COUNT stays 4; subsequent reads never return 0x55.
- Underflow: from reset, assert READ_EN -> UNDERFLOW_OR pulses for one cycle; VALID_OR stays 0; COUNT stays 0.
- Simultaneous and wrap:
  - With count 2, hold read+write for 10 cycles -> COUNT stays 2, pointers wrap at least twice, output order is preserved.
  - At full with read+write -> read accepted, OVERFLOW pulses, COUNT goes to 3.
- FWFT=1:
  - Write 0xA5 to the empty FIFO -> DATA_OUT_O=0xA5 and EMPTY=0 after that edge with no READ_EN.
  - Then write 0x5A and pop -> DATA_OUT_O=0x5A.
- Async reset: drop RST_N_IW mid-cycle at count 3 -> outputs clear before the next clock edge (COUNT=0, EMPTY=1); a write after release returns that word first.

Source files
------------

// File: rtl/fifo_sync_flags_if.sv
// Handshake and status bundle for fifo_sync_flags.
// The master side is the producer/consumer; the slave side is the FIFO itself.
interface fifo_sync_flags_if #(
    parameter int DATA_LEN = 8,
    parameter int DEPTH    = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_LEN-1:0] DATA_IN_I;
    logic                WRITE_EN_IW;
    logic                READ_EN_IW;
    logic [DATA_LEN-1:0] DATA_OUT_O;
    logic                VALID_OR;
    logic                FULL_OW;
    logic                EMPTY_OW;
    logic                ALMOST_FULL_OW;
    logic                ALMOST_EMPTY_OW;
    logic [CW-1:0]       COUNT_OR;
    logic                OVERFLOW_OR;
    logic                UNDERFLOW_OR;

    modport master (
        output DATA_IN_I, WRITE_EN_IW, READ_EN_IW,
        input  DATA_OUT_O, VALID_OR, FULL_OW, EMPTY_OW, ALMOST_FULL_OW,
               ALMOST_EMPTY_OW, COUNT_OR, OVERFLOW_OR, UNDERFLOW_OR
    );

    modport slave (
        input  DATA_IN_I, WRITE_EN_IW, READ_EN_IW,
        output DATA_OUT_O, VALID_OR, FULL_OW, EMPTY_OW, ALMOST_FULL_OW,
               ALMOST_EMPTY_OW, COUNT_OR, OVERFLOW_OR, UNDERFLOW_OR
    );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses and selectable standard or FWFT read mode.
module fifo_sync_flags #(
    parameter int DATA_LEN = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input logic             CLK_IW,
    input logic             RST_N_IW,
    fifo_sync_flags_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DATA_LEN < 1) begin : g_bad_len
        $error("fifo_sync_flags: DATA_LEN must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync_flags: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_sync_flags: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync_flags: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic [PW-1:0]       write_ptr;
    logic [PW-1:0]       read_ptr;
    logic [PW-1:0]       count;
    logic [DATA_LEN-1:0] mem [DEPTH];
    logic                full;
    logic                empty;
    logic                wr_ok;
    logic                rd_ok;
    logic                ovf_q;
    logic                udf_q;

    assign full  = (count == PW'(DEPTH));
    assign empty = (count == '0);
    assign wr_ok = bus.WRITE_EN_IW && !full;
    assign rd_ok = bus.READ_EN_IW && !empty;

    assign bus.FULL_OW         = full;
    assign bus.EMPTY_OW        = empty;
    assign bus.ALMOST_FULL_OW  = (int'(count) >= AF_LEVEL);
    assign bus.ALMOST_EMPTY_OW = (int'(count) <= AE_LEVEL);
    assign bus.COUNT_OR        = count;
    assign bus.OVERFLOW_OR     = ovf_q;
    assign bus.UNDERFLOW_OR    = udf_q;

    // Count is kept as its own register so the flags decode from a flop,
    // but it always tracks write_ptr - read_ptr.
    always_ff @(posedge CLK_IW or negedge RST_N_IW) begin
        if (!RST_N_IW) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            if (wr_ok) write_ptr <= write_ptr + PW'(1);
            if (rd_ok) read_ptr  <= read_ptr + PW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
            ovf_q <= bus.WRITE_EN_IW && full;
            udf_q <= bus.READ_EN_IW && empty;
        end
    end

    // Storage is not reset; a write landing on an edge held in reset is dropped.
    always_ff @(posedge CLK_IW) begin
        if (wr_ok && RST_N_IW) mem[write_ptr[AW-1:0]] <= bus.DATA_IN_I;
    end

    if (FWFT != 0) begin : g_fwft
        assign bus.DATA_OUT_O = mem[read_ptr[AW-1:0]];
        assign bus.VALID_OR   = 1'b0;
    end else begin : g_std
        logic [DATA_LEN-1:0] dout_q;
        logic                valid_q;

        always_ff @(posedge CLK_IW or negedge RST_N_IW) begin
            if (!RST_N_IW) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_ok;
                if (rd_ok) dout_q <= mem[read_ptr[AW-1:0]];
            end
        end

        assign bus.DATA_OUT_O = dout_q;
        assign bus.VALID_OR   = valid_q;
    end
endmodule
